score_row_max_sub: RTL
======================

Name: score_row_max_sub

Overview:
- Stage directly downstream of the 4-head score calculator.
- Reads the 64 FP32 attention scores through the calculator's score read port. Each score sits at address head*16 + i*4 + j.
- For each of the 16 rows (head, i) it finds the FP32 max over j = 0..3, subtracts that max from every element using one shared `adder` instance, and streams the results out with a valid/ready handshake.
- Its output feeds the softmax exp stage.

Parameters:
- RD_LAT, 1, cycles from score_rd_en asserted to score_rd_data valid (1..4).
- NUM_ROWS, 16, rows processed per run; row length is fixed at 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  start request; a rising edge (0->1 vs previous cycle) starts a run
- score_rd_addr  out  6  score read address = row*4 + j
- score_rd_en  out  1  score read strobe, 1-cycle pulse
- score_rd_data  in  32  FP32 score, valid RD_LAT cycles after the strobe
- out_data  out  32  FP32 score minus row max
- out_idx  out  6  linear index of out_data (row*4 + j)
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- busy  out  1  run in progress
- done  out  1  1-cycle pulse at end of run

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, row=j=0, max=0, buf[0..3]=0.
- Adder: active-high reset driven by a registered pulse that is 1 while rst=0 and 1 cycle after release; all adder strobes 0.
- IDLE:
  - busy=0.
  - Start edge: busy<=1, row<=0, j<=0, go RD_ISSUE.
  - A start edge while busy is ignored.
- RD_ISSUE: score_rd_addr<=row*4+j, score_rd_en<=1 for 1 cycle, wait counter<=0, go RD_WAIT.
- RD_WAIT: count RD_LAT cycles, then go CAPTURE.
- CAPTURE:
  - buf[j]<=score_rd_data.
  - If j==0, max<=data; else max<=data when data > max.
  - If j<3: j++, go RD_ISSUE; else j<=0, go SUB_START.
- FP32 compare (combinational), with a = new, b = max:
  - Signs differ: the positive one is greater; +0 and -0 are equal.
  - Both positive: larger {exp,mant} is greater.
  - Both negative: smaller {exp,mant} is greater.
  - Ties keep the earlier element.
  - NaN/Inf are not special-cased; the bit rule above applies.
- SUB_START: adder input_a=buf[j], input_b={~max[31],max[30:0]}, both stb<=1, go SUB_WAIT.
- SUB_WAIT:
  - Drop each stb on its ack.
  - On output_z_stb, capture output_z into out_data, set out_idx=row*4+j, out_valid<=1, go OUT_HOLD.
  - output_z_ack tied 1.
- OUT_HOLD:
  - out_data and out_idx are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid<=0 in the next cycle.
  - If j<3: j++, go SUB_START.
  - Else if row==NUM_ROWS-1: done<=1 (1 cycle), busy<=0, go IDLE.
  - Else row++, j<=0, go RD_ISSUE.
- Output ordering: strictly ascending out_idx, 4 outputs per row, NUM_ROWS*4 outputs per run.
- Simultaneous events: done pulses in the same cycle that busy falls. A start edge in that cycle is ignored; it must arrive after return to IDLE.
- Reset mid-run: aborts immediately with no done pulse; the next start begins at row 0.

Optional Feature:
- Macro: SCORE_ROW_MAX_EXPORT_EN.
- Defined:
  - Adds output row_max_flat [NUM_ROWS*32-1:0] = {max[NUM_ROWS-1],...,max[0]}.
  - Each row's max is written on leaving CAPTURE for j=3.
  - The bus is cleared to 0 on reset only, not on start.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Row 0 = 3F800000, 40000000, BF800000, 3F000000 (1, 2, -1, 0.5) -> max 2.0; outputs idx 0..3 = BF800000, zero (sign bit not checked), C0400000, BFC00000.
- Row 1 = BF800000, C0000000, C0400000, C0800000 (all negative) -> max -1.0; outputs zero, BF800000, C0000000, C0400000.
- Row with tie 40000000, 40000000, 3F800000, 80000000 -> max 2.0; outputs zero, zero, BF800000, C0000000; with macro, row_max_flat slice = 40000000.
- Backpressure: out_ready=0 for 5 cycles at idx 5 -> out_valid stays 1; out_data and out_idx stay constant; no read strobe issued; the run completes with 64 outputs in order.
- RD_LAT=3 build: score_rd_data is presented exactly 3 cycles after each strobe -> identical outputs to the RD_LAT=1 run.
- Assert rst low at output idx 20 -> all outputs 0 immediately, no done pulse; a new start edge gives a full 64-output run starting at idx 0; done pulses exactly once.

Source files
------------

// File: rtl/score_row_max_sub.sv
// Row-max subtract stage: per 4-wide score row, subtract the FP32 row max.
// Optional SCORE_ROW_MAX_EXPORT_EN exports every row max on row_max_flat.
module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d, sum_z;
    logic        ha_q, ha_d, hb_q, hb_d, zs_q, zs_d;
    logic        swap, sub, found;
    logic [31:0] x, y;
    logic [7:0]  e_l, e_s, d;
    logic [23:0] m_l, m_s;
    logic [49:0] ext;
    logic [27:0] sum;
    logic [26:0] m;
    logic [9:0]  e, sh;
    logic [24:0] rnd;

    assign input_a_ack  = ~ha_q;
    assign input_b_ack  = ~hb_q;
    assign output_z     = z_q;
    assign output_z_stb = zs_q;

    // Larger magnitude goes to x so the aligned subtraction never goes negative
    always_comb begin
        swap = a_q[30:0] < b_q[30:0];
        x    = swap ? b_q : a_q;
        y    = swap ? a_q : b_q;
        e_l  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        e_s  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        m_l  = {|x[30:23], x[22:0]};
        m_s  = {|y[30:23], y[22:0]};
        d    = e_l - e_s;
        ext  = {m_s, 26'd0} >> d;
        sub  = x[31] ^ y[31];
        sum  = sub ? ({1'b0, m_l, 3'd0} - {1'b0, ext[49:24], |ext[23:0]})
                   : ({1'b0, m_l, 3'd0} + {1'b0, ext[49:24], |ext[23:0]});
        e    = {2'd0, e_l};
        m    = sum[26:0];
        if (sum[27]) begin
            m = {sum[27:2], |sum[1:0]};
            e = e + 10'd1;
        end
        sh    = 10'd0;
        found = 1'b0;
        for (int k = 26; k >= 0; k--) begin
            if (!found) begin
                if (m[k]) found = 1'b1;
                else sh = sh + 10'd1;
            end
        end
        if (sh > e - 10'd1) sh = e - 10'd1;
        m   = m << sh;
        e   = e - sh;
        rnd = {1'b0, m[26:3]} + {24'd0, m[2] & (|m[1:0] | m[3])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'd1;
        end
        if (m == 27'd0) sum_z = 32'd0;
        else if (e >= 10'd255) sum_z = {x[31], 8'hFF, 23'd0};
        else sum_z = {x[31], rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
        if (x[30:23] == 8'hFF)
            sum_z = (sub && y[30:23] == 8'hFF) ? 32'h7FC00000 : x;
    end

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        z_d  = z_q;
        ha_d = ha_q;
        hb_d = hb_q;
        zs_d = zs_q;
        if (input_a_stb && !ha_q) begin
            a_d  = input_a;
            ha_d = 1'b1;
        end
        if (input_b_stb && !hb_q) begin
            b_d  = input_b;
            hb_d = 1'b1;
        end
        if (zs_q && output_z_ack) begin
            zs_d = 1'b0;
            ha_d = 1'b0;
            hb_d = 1'b0;
        end else if (ha_q && hb_q && !zs_q) begin
            z_d  = sum_z;
            zs_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            z_q  <= 32'd0;
            ha_q <= 1'b0;
            hb_q <= 1'b0;
            zs_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            z_q  <= z_d;
            ha_q <= ha_d;
            hb_q <= hb_d;
            zs_q <= zs_d;
        end
    end
endmodule

module score_row_max_sub #(
    parameter int RD_LAT   = 1,
    parameter int NUM_ROWS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  score_rd_addr,
    output logic        score_rd_en,
    input  logic [31:0] score_rd_data,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
`ifdef SCORE_ROW_MAX_EXPORT_EN
    ,
    output logic [NUM_ROWS*32-1:0] row_max_flat
`endif
);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, CAPTURE, SUB_START, SUB_WAIT, OUT_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [1:0]      j_q, j_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     max_q, max_d, max_new;
    logic [3:0][31:0] sbuf_q, sbuf_d;
    logic            start_q, busy_q, busy_d, done_q, done_d;
    logic            rd_en_q, rd_en_d, out_valid_q, out_valid_d;
    logic [5:0]      rd_addr_q, rd_addr_d, out_idx_q, out_idx_d, idx;
    logic [31:0]     out_data_q, out_data_d, opa_q, opa_d, opb_q, opb_d;
    logic            a_stb_q, a_stb_d, b_stb_q, b_stb_d, adder_rst_q;
    logic            a_ack, b_ack, z_stb;
    logic [31:0]     z;
`ifdef SCORE_ROW_MAX_EXPORT_EN
    logic [NUM_ROWS*32-1:0] row_max_q, row_max_d;
    assign row_max_flat = row_max_q;
`endif

    // Sign-magnitude ordering; +0 and -0 compare equal, ties keep the old max
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return !a[31] && (|{a[30:0], b[30:0]});
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    assign idx     = 6'({row_q, j_q});
    assign max_new = (j_q == 2'd0 || fp_gt(score_rd_data, max_q))
                     ? score_rd_data : max_q;

    assign score_rd_addr = rd_addr_q;
    assign score_rd_en   = rd_en_q;
    assign out_data      = out_data_q;
    assign out_idx       = out_idx_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

    adder u_adder (
        .clk          (clk),
        .rst          (adder_rst_q),
        .input_a      (opa_q),
        .input_a_stb  (a_stb_q),
        .input_a_ack  (a_ack),
        .input_b      (opb_q),
        .input_b_stb  (b_stb_q),
        .input_b_ack  (b_ack),
        .output_z     (z),
        .output_z_stb (z_stb),
        .output_z_ack (1'b1)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        j_d         = j_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        sbuf_d      = sbuf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
`ifdef SCORE_ROW_MAX_EXPORT_EN
        row_max_d   = row_max_q;
`endif
        unique case (state_q)
            IDLE: begin
                // done_q high means this is the cycle busy fell: ignore start
                if (start && !start_q && !done_q) begin
                    busy_d  = 1'b1;
                    row_d   = '0;
                    j_d     = 2'd0;
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                rd_addr_d = idx;
                rd_en_d   = 1'b1;
                cnt_d     = 3'd0;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(RD_LAT - 1)) state_d = CAPTURE;
            end
            CAPTURE: begin
                sbuf_d[j_q] = score_rd_data;
                max_d       = max_new;
                if (j_q != 2'd3) begin
                    j_d     = j_q + 2'd1;
                    state_d = RD_ISSUE;
                end else begin
`ifdef SCORE_ROW_MAX_EXPORT_EN
                    row_max_d[row_q*32 +: 32] = max_new;
`endif
                    j_d     = 2'd0;
                    state_d = SUB_START;
                end
            end
            SUB_START: begin
                opa_d   = sbuf_q[j_q];
                opb_d   = {~max_q[31], max_q[30:0]};
                a_stb_d = 1'b1;
                b_stb_d = 1'b1;
                state_d = SUB_WAIT;
            end
            SUB_WAIT: begin
                if (a_stb_q && a_ack) a_stb_d = 1'b0;
                if (b_stb_q && b_ack) b_stb_d = 1'b0;
                if (z_stb) begin
                    out_data_d  = z;
                    out_idx_d   = idx;
                    out_valid_d = 1'b1;
                    state_d     = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (j_q != 2'd3) begin
                        j_d     = j_q + 2'd1;
                        state_d = SUB_START;
                    end else if (row_q == RW'(NUM_ROWS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        j_d     = 2'd0;
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) adder_rst_q <= 1'b1;
        else adder_rst_q <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            j_q         <= 2'd0;
            cnt_q       <= 3'd0;
            max_q       <= 32'd0;
            sbuf_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 6'd0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 6'd0;
            out_data_q  <= 32'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
`ifdef SCORE_ROW_MAX_EXPORT_EN
            row_max_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            j_q         <= j_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            sbuf_q      <= sbuf_d;
            start_q     <= start;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
`ifdef SCORE_ROW_MAX_EXPORT_EN
            row_max_q   <= row_max_d;
`endif
        end
    end
endmodule
